// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between host, uart_tx_fifo and the downstream uart_tx.
// The slave modport is the FIFO's view; master is the host/transmitter side.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_parity;
    logic                  full;
    logic                  empty;
    logic [AW:0]           level;
    logic                  overflow;
    logic                  tx_ready;
    logic                  tx_done;
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  parity;
    logic                  busy;

    modport slave (
        input  wr_en, wr_data, wr_parity, tx_ready, tx_done,
        output full, empty, level, overflow, start, tx_data, parity, busy
    );

    modport master (
        output wr_en, wr_data, wr_parity, tx_ready, tx_done,
        input  full, empty, level, overflow, start, tx_data, parity, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer with per-word parity flag that feeds uart_tx through
// its start/ready/done handshake; the head entry is popped only on tx_done.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_parity;
    logic                  r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_load;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = bus.wr_en && !w_full;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && bus.tx_ready) begin
                    w_load       = 1'b1;
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!bus.tx_ready) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    w_pop        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_tx_data  <= '0;
            r_parity   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_overflow <= bus.wr_en && w_full;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_load) begin
                r_tx_data <= r_mem[r_rd_ptr][DATA_WIDTH-1:0];
                r_parity  <= r_mem[r_rd_ptr][DATA_WIDTH];
            end
        end
    end

    // Storage is not reset; full blocks any write into the still-unpopped head slot.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.wr_parity, bus.wr_data};
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
    assign bus.start    = (r_state == S_LAUNCH);
    assign bus.tx_data  = r_tx_data;
    assign bus.parity   = r_parity;
    assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: the initial block plays both host and the
// uart_tx handshake partner, with a queue holding the expected word order.
module tb_uart_tx_fifo;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    logic [8:0] q[$];

    uart_tx_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        bus.wr_en     = 1'b1;
        bus.wr_data   = d;
        bus.wr_parity = p;
        tick();
        bus.wr_en     = 1'b0;
    endtask

    // Waits (bounded) for start, checks the launched word, then completes the handshake.
    task automatic xfer(input logic [7:0] d, input logic p);
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 8 && bus.start !== 1'b1; k++) tick();
        chk("start_seen", 32'(bus.start), 32'h1);
        chk("tx_data", 32'(bus.tx_data), 32'(d));
        chk("parity", 32'(bus.parity), 32'(p));
        bus.tx_ready = 1'b0;
        tick();
        chk("start_drop", 32'(bus.start), 32'h0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done  = 1'b0;
        bus.tx_ready = 1'b1;
    endtask

    initial begin
        logic [8:0] e;
        logic [7:0] d;
        logic       p;
        int         pushed;
        n_total = 0;
        n_pass  = 0;
        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.wr_parity = 1'b0;
        bus.tx_ready  = 1'b0;
        bus.tx_done   = 1'b0;
        tick();
        tick();
        chk("rst_start", 32'(bus.start), 32'h0);
        chk("rst_level", 32'(bus.level), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ovf", 32'(bus.overflow), 32'h0);
        chk("rst_txdata", 32'(bus.tx_data), 32'h0);
        chk("rst_parity", 32'(bus.parity), 32'h0);
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of LAUNCH with 3 entries stored
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        push(8'h33, 1'b0);
        chk("pre_level3", 32'(bus.level), 32'h3);
        bus.tx_ready = 1'b1;
        tick();
        chk("launch_start", 32'(bus.start), 32'h1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_start", 32'(bus.start), 32'h0);
        chk("async_level", 32'(bus.level), 32'h0);
        chk("async_empty", 32'(bus.empty), 32'h1);
        chk("async_busy", 32'(bus.busy), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_start", 32'(bus.start), 32'h0);
        chk("post_rst_level", 32'(bus.level), 32'h0);

        // Single word, 2-cycle push-to-start latency
        push(8'hA5, 1'b1);
        chk("sw_level1", 32'(bus.level), 32'h1);
        chk("sw_empty0", 32'(bus.empty), 32'h0);
        chk("sw_start0", 32'(bus.start), 32'h0);
        tick();
        chk("sw_start1", 32'(bus.start), 32'h1);
        chk("sw_data", 32'(bus.tx_data), 32'hA5);
        chk("sw_par", 32'(bus.parity), 32'h1);
        bus.tx_ready = 1'b0;
        tick();
        chk("sw_wait_start", 32'(bus.start), 32'h0);
        chk("sw_wait_busy", 32'(bus.busy), 32'h1);
        chk("sw_wait_level", 32'(bus.level), 32'h1);
        bus.tx_done = 1'b1;
        tick();
        chk("sw_pop_level", 32'(bus.level), 32'h0);
        chk("sw_pop_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("done_idle_level", 32'(bus.level), 32'h0);
        chk("done_idle_busy", 32'(bus.busy), 32'h0);
        bus.tx_done = 1'b0;

        // Fill to full with the transmitter stalled, then overflow
        for (int i = 0; i < 16; i++) push(8'(i), 1'(i & 1));
        chk("fill_full", 32'(bus.full), 32'h1);
        chk("fill_level", 32'(bus.level), 32'd16);
        chk("fill_start", 32'(bus.start), 32'h0);
        push(8'hFF, 1'b1);
        chk("ovf_pulse", 32'(bus.overflow), 32'h1);
        chk("ovf_level", 32'(bus.level), 32'd16);
        tick();
        chk("ovf_clear", 32'(bus.overflow), 32'h0);
        for (int i = 0; i < 16; i++) xfer(8'(i), 1'(i & 1));
        chk("drain_empty", 32'(bus.empty), 32'h1);
        tick();
        tick();
        chk("no_ff_start", 32'(bus.start), 32'h0);
        chk("no_ff_level", 32'(bus.level), 32'h0);

        // Push coincident with the pop at level 5
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i), 1'(i & 1));
        bus.tx_ready = 1'b1;
        tick();
        chk("sim_start", 32'(bus.start), 32'h1);
        chk("sim_data0", 32'(bus.tx_data), 32'h20);
        bus.tx_ready = 1'b0;
        tick();
        chk("sim_level5", 32'(bus.level), 32'd5);
        bus.tx_done   = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_data   = 8'h26;
        bus.wr_parity = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        bus.wr_en   = 1'b0;
        chk("sim_level_hold", 32'(bus.level), 32'd5);
        xfer(8'h21, 1'b1);
        xfer(8'h22, 1'b0);
        xfer(8'h23, 1'b1);
        xfer(8'h24, 1'b0);
        xfer(8'h26, 1'b1);
        chk("sim_empty", 32'(bus.empty), 32'h1);

        // Random stream of 40 words, level kept small so pointers wrap repeatedly
        pushed = 0;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            q.push_back({p, d});
            push(d, p);
            pushed++;
        end
        for (int i = 0; i < 40; i++) begin
            if (pushed < 40) begin
                d = 8'($urandom);
                p = 1'($urandom);
                q.push_back({p, d});
                push(d, p);
                pushed++;
            end
            e = q.pop_front();
            xfer(e[7:0], e[8]);
        end
        chk("wrap_empty", 32'(bus.empty), 32'h1);
        chk("wrap_level", 32'(bus.level), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
